// File: rtl/mem_lsu_stage_pkg.sv
// Shared definitions for the MEM load/store stage: memop one-hot layout,
// FSM state encoding and drop-counter sizing helper.
package mem_lsu_stage_pkg;

    // One-hot memop vector {lwr,lwl,lw,lhu,lh,lbu,lb}, bit 0 = lb
    localparam int MMOP_W  = 7;
    localparam int MOP_LB  = 0;
    localparam int MOP_LBU = 1;
    localparam int MOP_LH  = 2;
    localparam int MOP_LHU = 3;
    localparam int MOP_LW  = 4;
    localparam int MOP_LWL = 5;
    localparam int MOP_LWR = 6;

    // IDLE: nothing outstanding for the instruction in MEM
    // WAIT: request issued, response not yet seen
    // HOLD: response captured in rbuf while the pipe is globally stalled
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } lsu_state_e;

    // Bits needed to count 0..max_outst orphaned responses
    function automatic int drop_cnt_w(input int max_outst);
        return (max_outst < 1) ? 1 : $clog2(max_outst + 1);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data formatter: byte/half selection with sign or zero
// extension, full word pass-through, and LWL/LWR merge with the old rt.
module mem_load_align
    import mem_lsu_stage_pkg::*;
#(
    parameter bit EN_LWLR = 1'b1
)(
    input  logic [MMOP_W-1:0] memop,
    input  logic [1:0]        addr_low,
    input  logic [31:0]       rdata,
    input  logic [31:0]       rt,
    output logic [31:0]       result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lwl_res;
    logic [31:0] lwr_res;

    // Little-endian byte lane select
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_low)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Half-word select uses only the upper address bit
    assign half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];

    // LWL: low bytes of memory word fill the top of rt; LWR: high bytes fill the bottom
    always_comb begin
        lwl_res = rdata;
        lwr_res = rdata;
        case (addr_low)
            2'd0: begin
                lwl_res = {rdata[7:0],  rt[23:0]};
                lwr_res = rdata;
            end
            2'd1: begin
                lwl_res = {rdata[15:0], rt[15:0]};
                lwr_res = {rt[31:24],   rdata[31:8]};
            end
            2'd2: begin
                lwl_res = {rdata[23:0], rt[7:0]};
                lwr_res = {rt[31:16],   rdata[31:16]};
            end
            2'd3: begin
                lwl_res = rdata;
                lwr_res = {rt[31:8],    rdata[31:24]};
            end
            default: begin
                lwl_res = rdata;
                lwr_res = rdata;
            end
        endcase
    end

    // Result mux driven by the one-hot memop; no bit set yields zero
    always_comb begin
        result = 32'h0;
        if (memop[MOP_LB])
            result = {{24{byte_sel[7]}}, byte_sel};
        else if (memop[MOP_LBU])
            result = {24'h0, byte_sel};
        else if (memop[MOP_LH])
            result = {{16{half_sel[15]}}, half_sel};
        else if (memop[MOP_LHU])
            result = {16'h0, half_sel};
        else if (memop[MOP_LW])
            result = rdata;
        else if (memop[MOP_LWL])
            result = EN_LWLR ? lwl_res : 32'h0;
        else if (memop[MOP_LWR])
            result = EN_LWLR ? lwr_res : 32'h0;
    end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage for a variable-latency data bus. Waits for the bus
// response of the instruction in MEM, buffers it across global stalls,
// discards responses orphaned by flushes, and registers results towards WB.
module mem_lsu_stage
    import mem_lsu_stage_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter bit EN_LWLR   = 1'b1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_pc,
    input  logic              in_inslot,
    input  logic [MMOP_W-1:0] in_memop,
    input  logic [1:0]        in_addr_low,
    input  logic              in_req_issued,
    input  logic              in_is_load,
    input  logic [4:0]        in_waddr,
    input  logic [31:0]       in_wdata,
    input  logic              in_wren,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              dbus_data_ok,
    input  logic [31:0]       dbus_rdata,
    output logic              out_valid,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic              out_inslot,
    output logic [4:0]        out_waddr,
    output logic [31:0]       out_wdata,
    output logic              out_wren,
    output logic              bp_valid,
    output logic [31:0]       bp_wdata,
    output logic              stall_o,
    output logic              drop_full
);

    localparam int             DCW      = drop_cnt_w(MAX_OUTST);
    localparam logic [DCW-1:0] DROP_MAX = DCW'(MAX_OUTST);
    localparam logic [DCW-1:0] DROP_ONE = DCW'(1);

    lsu_state_e     state_reg, state_next;
    logic [DCW-1:0] drop_cnt_reg, drop_cnt_next;
    logic           rbuf_vld_reg;
    logic [31:0]    rbuf_reg;

    logic           out_valid_reg;
    logic [31:0]    out_inst_reg;
    logic [31:0]    out_pc_reg;
    logic           out_inslot_reg;
    logic [4:0]     out_waddr_reg;
    logic [31:0]    out_wdata_reg;
    logic           out_wren_reg;

    logic           drop_zero;
    logic           need;
    logic           got;
    logic           en;
    logic           capture;
    logic [31:0]    rdata_sel;
    logic [31:0]    align_res;

    // A response belongs to the instruction in MEM only once all orphans are drained
    assign drop_zero = (drop_cnt_reg == '0);
    assign need      = in_valid & in_req_issued;
    assign got       = rbuf_vld_reg | (dbus_data_ok & drop_zero);
    assign stall_o   = need & ~got & ~flush_i;
    assign en        = ~stall_i & ~stall_o;
    assign drop_full = (drop_cnt_reg == DROP_MAX);

    // Own response arriving while the pipe is held must be parked in rbuf
    assign capture   = need & stall_i & ~rbuf_vld_reg & dbus_data_ok & drop_zero;

    assign rdata_sel = rbuf_vld_reg ? rbuf_reg : dbus_rdata;

    assign bp_valid  = in_valid & in_wren & ~in_is_load;
    assign bp_wdata  = in_wdata;

    assign out_valid  = out_valid_reg;
    assign out_inst   = out_inst_reg;
    assign out_pc     = out_pc_reg;
    assign out_inslot = out_inslot_reg;
    assign out_waddr  = out_waddr_reg;
    assign out_wdata  = out_wdata_reg;
    assign out_wren   = out_wren_reg;

    mem_load_align #(
        .EN_LWLR (EN_LWLR)
    ) u_align (
        .memop    (in_memop),
        .addr_low (in_addr_low),
        .rdata    (rdata_sel),
        .rt       (in_wdata),
        .result   (align_res)
    );

    // Drop counter: orphan responses retire first; a flush with our response
    // still pending adds one. Both in the same cycle cancel out.
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (dbus_data_ok && !drop_zero)
            drop_cnt_next = drop_cnt_next - DROP_ONE;
        if (flush_i && need && !got && (drop_cnt_next != DROP_MAX))
            drop_cnt_next = drop_cnt_next + DROP_ONE;
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt_reg <= '0;
        else
            drop_cnt_reg <= drop_cnt_next;
    end

    // FSM next state; flush always returns to IDLE
    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (capture)
                        state_next = ST_HOLD;
                    else if (stall_o)
                        state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (capture)
                        state_next = ST_HOLD;
                    else if (en)
                        state_next = ST_IDLE;
                end
                ST_HOLD: begin
                    if (!stall_i)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // One-entry response buffer, consumed when the output register advances
    always_ff @(posedge clk) begin
        if (rst) begin
            rbuf_vld_reg <= 1'b0;
            rbuf_reg     <= 32'h0;
        end else if (flush_i || en) begin
            rbuf_vld_reg <= 1'b0;
        end else if (capture) begin
            rbuf_vld_reg <= 1'b1;
            rbuf_reg     <= dbus_rdata;
        end
    end

    // Output register to WB: flush kills, advance loads, bus wait inserts a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_inst_reg   <= 32'h0;
            out_pc_reg     <= 32'h0;
            out_inslot_reg <= 1'b0;
            out_waddr_reg  <= 5'h0;
            out_wdata_reg  <= 32'h0;
            out_wren_reg   <= 1'b0;
        end else if (flush_i) begin
            out_valid_reg  <= 1'b0;
            out_wren_reg   <= 1'b0;
        end else if (en) begin
            out_valid_reg  <= in_valid;
            out_inst_reg   <= in_inst;
            out_pc_reg     <= in_pc;
            out_inslot_reg <= in_inslot;
            out_waddr_reg  <= in_waddr;
            out_wdata_reg  <= in_is_load ? align_res : in_wdata;
            out_wren_reg   <= in_valid & in_wren;
        end else if (!stall_i) begin
            out_valid_reg  <= 1'b0;
            out_wren_reg   <= 1'b0;
        end
    end

endmodule
